// File: rtl/adc_stream_pkg.sv
// Shared types and constants for the ADC acquisition/streaming controller.
package adc_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETDIV,
    ST_CAPTURE,
    ST_DUMP,
    ST_STREAM
  } state_e;

  localparam logic [7:0] CMD_STOP    = 8'h00;
  localparam logic [7:0] CMD_CAPTURE = 8'h01;
  localparam logic [7:0] CMD_SETDIV  = 8'h02;
  localparam logic [7:0] CMD_STREAM  = 8'h03;
  localparam logic [7:0] HEADER      = 8'hA5;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, extra-MSB pointers and a flush.
module sync_fifo #(
  parameter int W     = 13,
  parameter int DEPTH = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic [W-1:0]             wr_data_i,
  input  logic                     rd_en_i,
  output logic [W-1:0]             rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [W-1:0]  rd_data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)        rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
  end

  // Same index with differing MSB means the writer has lapped the reader.
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/adc_stream_ctrl.sv
// ADC acquisition controller: conversion clock, sample FIFO, command FSM and
// byte serialiser toward the UART/FT245 transmit path.
module adc_stream_ctrl
  import adc_stream_pkg::*;
#(
  parameter int ADC_W    = 12,
  parameter int DEPTH    = 256,
  parameter int DIV_W    = 8,
  parameter int DIV_INIT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [ADC_W-1:0] ADC_BIT,
  input  logic             ADC_OTR,
  output logic             ADC_CLK,
  output logic             ADC_OE,
  input  logic [7:0]       CMD_DATA,
  input  logic             CMD_VALID,
  output logic [7:0]       TX_DATA,
  output logic             TX_VALID,
  input  logic             TX_READY,
  output logic             BUSY,
  output logic             OVERFLOW
);

  localparam int                SW      = ADC_W + 1;
  localparam int                AW      = $clog2(DEPTH);
  localparam logic [AW:0]       LAST_WR = (AW+1)'(DEPTH - 1);
  localparam logic [DIV_W-1:0]  DIV_RST = DIV_W'(DIV_INIT);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
  logic             adc_clk_q, adc_clk_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       tx_data_q, tx_data_d, lsb_q, lsb_d;
  logic             tx_valid_q, tx_valid_d;
  logic             rvld_q, rvld_d, lsb_pend_q, lsb_pend_d, hdr_pend_q, hdr_pend_d;

  logic             stop, run, wrap, strobe, keep_run, drain, tx_free, consume;
  logic             wr_en, rd_en, full, empty;
  logic [SW-1:0]    rd_data;
  logic [AW:0]      count;
  logic [7:0]       msb_byte;

  sync_fifo #(.W(SW), .DEPTH(DEPTH)) u_fifo (
    .clk_i     (CLK),
    .rst_i     (RST),
    .flush_i   (stop),
    .wr_en_i   (wr_en),
    .wr_data_i ({ADC_OTR, ADC_BIT}),
    .rd_en_i   (rd_en),
    .rd_data_o (rd_data),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (count)
  );

  assign stop   = CMD_VALID && (CMD_DATA == CMD_STOP);
  assign run    = (state_q == ST_CAPTURE) || (state_q == ST_STREAM);
  assign drain  = (state_q == ST_DUMP) || (state_q == ST_STREAM);
  assign wrap   = run && (cnt_q == div_q);
  assign strobe = wrap && !adc_clk_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    unique case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          if (CMD_DATA == CMD_CAPTURE)     state_d = ST_CAPTURE;
          else if (CMD_DATA == CMD_SETDIV) state_d = ST_SETDIV;
          else if (CMD_DATA == CMD_STREAM) state_d = ST_STREAM;
        end
      end
      ST_SETDIV: begin
        // Any byte, including 0x00, is a divider value here.
        if (CMD_VALID) begin
          div_d   = DIV_W'(CMD_DATA);
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: if (strobe && (count == LAST_WR)) state_d = ST_DUMP;
      ST_DUMP: begin
        if (!hdr_pend_q && !lsb_pend_q && !rvld_q && empty && tx_valid_q && TX_READY)
          state_d = ST_IDLE;
      end
      ST_STREAM: ;
      default: state_d = ST_IDLE;
    endcase
    if (stop) state_d = ST_IDLE;
  end

  // Leaving a run state (end of capture or stop) parks the divider and ADC_CLK low.
  always_comb begin
    keep_run  = run && (state_d == state_q);
    cnt_d     = keep_run ? (wrap ? '0 : cnt_q + 1'b1) : '0;
    adc_clk_d = keep_run && (adc_clk_q ^ wrap);
  end

  always_comb begin
    msb_byte    = 8'(rd_data[ADC_W-1:8]);
    msb_byte[7] = rd_data[ADC_W];

    tx_free    = !tx_valid_q || TX_READY;
    tx_valid_d = tx_valid_q && !TX_READY;
    tx_data_d  = tx_data_q;
    lsb_d      = lsb_q;
    lsb_pend_d = lsb_pend_q;
    hdr_pend_d = hdr_pend_q || ((state_q == ST_CAPTURE) && (state_d == ST_DUMP));
    consume    = 1'b0;

    if (tx_free) begin
      if (hdr_pend_q) begin
        tx_valid_d = 1'b1;
        tx_data_d  = HEADER;
        hdr_pend_d = 1'b0;
      end else if (lsb_pend_q) begin
        tx_valid_d = 1'b1;
        tx_data_d  = lsb_q;
        lsb_pend_d = 1'b0;
      end else if (rvld_q) begin
        tx_valid_d = 1'b1;
        tx_data_d  = msb_byte;
        lsb_d      = rd_data[7:0];
        lsb_pend_d = 1'b1;
        consume    = 1'b1;
      end
    end

    // Keep exactly one sample staged in the FIFO read register.
    rd_en  = drain && !empty && (!rvld_q || consume);
    rvld_d = rd_en || (rvld_q && !consume);

    wr_en = 1'b0;
    if (state_q == ST_CAPTURE)     wr_en = strobe;
    else if (state_q == ST_STREAM) wr_en = strobe && (!full || rd_en);

    ovf_d = ovf_q || ((state_q == ST_STREAM) && strobe && full && !rd_en);

    if (stop) begin
      tx_valid_d = 1'b0;
      tx_data_d  = '0;
      lsb_pend_d = 1'b0;
      hdr_pend_d = 1'b0;
      rvld_d     = 1'b0;
      ovf_d      = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      div_q      <= DIV_RST;
      cnt_q      <= '0;
      adc_clk_q  <= 1'b0;
      ovf_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      lsb_q      <= '0;
      lsb_pend_q <= 1'b0;
      hdr_pend_q <= 1'b0;
      rvld_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      adc_clk_q  <= adc_clk_d;
      ovf_q      <= ovf_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      lsb_q      <= lsb_d;
      lsb_pend_q <= lsb_pend_d;
      hdr_pend_q <= hdr_pend_d;
      rvld_q     <= rvld_d;
    end
  end

  assign ADC_CLK  = adc_clk_q;
  assign ADC_OE   = !run;
  assign TX_DATA  = tx_data_q;
  assign TX_VALID = tx_valid_q;
  assign BUSY     = (state_q != ST_IDLE);
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_adc_stream_ctrl.sv
// Randomized bench for adc_stream_ctrl against a cycle-arithmetic reference model.
module tb_adc_stream_ctrl;

  localparam int ADC_W = 12;
  localparam int DEPTH = 16;
  localparam int DIV_INIT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [ADC_W-1:0] adc_bit;
  logic             adc_otr;
  logic             adc_clk, adc_oe;
  logic [7:0]       cmd_data;
  logic             cmd_valid;
  logic [7:0]       tx_data;
  logic             tx_valid, tx_ready;
  logic             busy, overflow;

  int errs = 0;
  int checks = 0;
  int mdiv = DIV_INIT;
  logic [7:0] q[$];
  logic [7:0] got[$];

  adc_stream_ctrl #(.ADC_W(ADC_W), .DEPTH(DEPTH), .DIV_W(8), .DIV_INIT(DIV_INIT)) dut (
    .CLK(clk), .RST(rst), .ADC_BIT(adc_bit), .ADC_OTR(adc_otr),
    .ADC_CLK(adc_clk), .ADC_OE(adc_oe), .CMD_DATA(cmd_data), .CMD_VALID(cmd_valid),
    .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready),
    .BUSY(busy), .OVERFLOW(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    cmd_data  = b;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  // ADC_CLK is low for DIV+1 cycles, then high for DIV+1, starting at entry.
  function automatic logic exp_clk(input int t, input int d);
    return 1'((t / (d + 1)) % 2);
  endfunction

  // True when the edge ending cycle t takes ADC_CLK 0 -> 1.
  function automatic bit strobe_at(input int t, input int d);
    return ((t + 1) % (d + 1) == 0) && (((t + 1) / (d + 1)) % 2 == 1);
  endfunction

  task automatic push_sample(input logic otr, input logic [ADC_W-1:0] b);
    logic [7:0] m;
    m = 8'(b >> 8);
    m[7] = otr;
    q.push_back(m);
    q.push_back(b[7:0]);
  endtask

  task automatic set_div(input int d);
    send_cmd(8'h02);
    chk("setdiv_busy", busy, 1);
    send_cmd(8'(d));
    chk("setdiv_idle", busy, 0);
    mdiv = d;
  endtask

  // dmode: 0 = 0x7E3/OTR0, 1 = 0xFFF/OTR1, 2 = random. rmode: 0 = ready, 1 = random, 2 = toggle.
  task automatic run_capture(input int dmode, input int rmode, input int abort_n);
    int t = 0;
    int nsamp = 0;
    bit done = 0;
    bit aborted = 0;
    q = {};
    got = {};
    q.push_back(8'hA5);
    send_cmd(8'h01);
    chk("cap_busy", busy, 1);
    for (int c = 0; c < 20000; c++) begin
      if (dmode == 0)      {adc_otr, adc_bit} = {1'b0, 12'h7E3};
      else if (dmode == 1) {adc_otr, adc_bit} = {1'b1, 12'hFFF};
      else                 {adc_otr, adc_bit} = 13'($urandom);
      tx_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom) : 1'(t);
      if (nsamp < DEPTH) begin
        chk("cap_adc_clk", adc_clk, exp_clk(t, mdiv));
        chk("cap_oe", adc_oe, 0);
      end else begin
        chk("dump_adc_clk", adc_clk, 0);
        chk("dump_oe", adc_oe, 1);
      end
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (nsamp < DEPTH && strobe_at(t, mdiv)) begin
        nsamp++;
        push_sample(adc_otr, adc_bit);
      end
      if (abort_n > 0 && nsamp == DEPTH && got.size() >= abort_n) begin
        cmd_data  = 8'h00;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        aborted = 1;
        break;
      end
      step();
      t++;
      if (nsamp == DEPTH && !busy) begin
        done = 1;
        break;
      end
    end
    if (aborted) begin
      chk("abort_txv", tx_valid, 0);
      chk("abort_busy", busy, 0);
      for (int c = 0; c < 40; c++) begin
        tx_ready = ~tx_ready;
        step();
        chk("abort_quiet", tx_valid, 0);
      end
    end else begin
      chk("cap_done", done, 1);
      chk("cap_end_txv", tx_valid, 0);
      chk("cap_nbytes", got.size(), q.size());
    end
    for (int i = 0; i < got.size() && i < q.size(); i++) chk("cap_byte", got[i], q[i]);
  endtask

  initial begin
    rst = 1'b1; adc_bit = '0; adc_otr = 1'b0;
    cmd_data = '0; cmd_valid = 1'b0; tx_ready = 1'b0;
    step(); step();
    chk("rst_adc_clk", adc_clk, 0);
    chk("rst_oe", adc_oe, 1);
    chk("rst_txv", tx_valid, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      tx_ready = 1'($urandom);
      step();
      chk("idle_adc_clk", adc_clk, 0);
      chk("idle_oe", adc_oe, 1);
      chk("idle_txv", tx_valid, 0);
    end
    send_cmd(8'h55);
    chk("bogus_cmd", busy, 0);

    set_div(3);
    run_capture(0, 0, 0);
    run_capture(1, 0, 0);
    run_capture(2, 1, 0);
    set_div(0);
    run_capture(2, 1, 0);

    // Stream into a stalled sink until samples must be dropped.
    tx_ready = 1'b0;
    send_cmd(8'h03);
    chk("ovf_start", overflow, 0);
    chk("ovf_oe", adc_oe, 0);
    for (int c = 0; c < (DEPTH + 4) * 2 * (mdiv + 1) + 2; c++) begin
      {adc_otr, adc_bit} = 13'($urandom);
      step();
    end
    chk("ovf_set", overflow, 1);
    send_cmd(8'h00);
    chk("ovf_clear", overflow, 0);
    chk("ovf_stop_oe", adc_oe, 1);
    chk("ovf_stop_busy", busy, 0);
    chk("ovf_stop_txv", tx_valid, 0);
    run_capture(2, 0, 0);

    // Random stream with a mostly-ready sink; output must be an in-order prefix.
    set_div(5);
    q = {};
    got = {};
    send_cmd(8'h03);
    for (int c = 0, t = 0; c < 600; c++, t++) begin
      {adc_otr, adc_bit} = 13'($urandom);
      tx_ready = ($urandom % 4) != 0;
      chk("strm_adc_clk", adc_clk, exp_clk(t, mdiv));
      chk("strm_oe", adc_oe, 0);
      chk("strm_ovf", overflow, 0);
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (strobe_at(t, mdiv)) push_sample(adc_otr, adc_bit);
      if (c == 599) begin
        cmd_data  = 8'h00;
        cmd_valid = 1'b1;
      end
      step();
      cmd_valid = 1'b0;
    end
    chk("strm_stop_txv", tx_valid, 0);
    chk("strm_stop_busy", busy, 0);
    chk("strm_progress", (got.size() + 8 >= q.size()) && (got.size() <= q.size()), 1);
    for (int i = 0; i < got.size() && i < q.size(); i++) chk("strm_byte", got[i], q[i]);

    run_capture(2, 2, 7);

    // Reset mid-stream, with a coincident command that must be ignored.
    tx_ready = 1'b0;
    send_cmd(8'h03);
    for (int c = 0; c < (DEPTH + 4) * 2 * (mdiv + 1) + 2; c++) step();
    chk("pre_rst_ovf", overflow, 1);
    rst = 1'b1;
    cmd_data = 8'h03;
    cmd_valid = 1'b1;
    step();
    rst = 1'b0;
    cmd_valid = 1'b0;
    chk("mrst_adc_clk", adc_clk, 0);
    chk("mrst_oe", adc_oe, 1);
    chk("mrst_txv", tx_valid, 0);
    chk("mrst_txd", tx_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ovf", overflow, 0);
    mdiv = DIV_INIT;
    run_capture(2, 1, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/adc_stream_ctrl.md
# adc_stream_ctrl

Parametrised ADC acquisition controller. It generates the ADC conversion clock and output enable, and captures samples plus the over-range flag. Captured data is buffered in an on-chip FIFO and serialised as a byte stream toward the UART/FT245 transmit path. Command bytes from the UART receiver select single-shot capture, continuous streaming, stop, or a divider change.

## Interface
- `ADC_W`, 12: ADC sample width; legal range 9..15.
- `DEPTH`, 256: FIFO depth in samples; must be a power of two; also the single-shot capture length.
- `DIV_W`, 8: width of the ADC clock divider.
- `DIV_INIT`, 4: divider value after reset.

- `CLK`  in  1  system clock; the only clock.
- `RST`  in  1  synchronous, active-high reset.
- `ADC_BIT`  in  ADC_W  ADC parallel data.
- `ADC_OTR`  in  1  ADC over-range flag.
- `ADC_CLK`  out  1  ADC conversion clock.
- `ADC_OE`  out  1  ADC output enable, active-low.
- `CMD_DATA`  in  8  command byte from the UART receiver.
- `CMD_VALID`  in  1  single-cycle strobe qualifying `CMD_DATA`.
- `TX_DATA`  out  8  outgoing byte.
- `TX_VALID`  out  1  `TX_DATA` is valid.
- `TX_READY`  in  1  sink accepts the byte.
- `BUSY`  out  1  high in any state other than IDLE.
- `OVERFLOW`  out  1  sticky flag: a sample was dropped in STREAM.

## Operation
- States: IDLE, SETDIV, CAPTURE, DUMP, STREAM.
- Commands are decoded only when `CMD_VALID` is high.
  - 0x01, from IDLE: go to CAPTURE.
  - 0x02, from IDLE: go to SETDIV. The next valid byte loads the divider, then return to IDLE.
  - 0x03, from IDLE: go to STREAM.
  - 0x00, from any state: go to IDLE, flush the FIFO, clear `OVERFLOW`, drop any partial byte.
  - All other bytes, and 0x01/0x02/0x03 outside IDLE, are ignored.
- ADC clock:
  - In IDLE and SETDIV, `ADC_CLK` is held 0.
  - In CAPTURE and STREAM, the divider counter runs 0..DIV and `ADC_CLK` toggles on each wrap, so the period is 2*(DIV+1) `CLK` cycles.
  - DIV=0 gives CLK/2.
- Sample strobe: asserted on the `CLK` edge where `ADC_CLK` is registered 0→1. On that edge {`ADC_OTR`, `ADC_BIT`} is written into the FIFO.
- `ADC_OE` is 0 in CAPTURE and STREAM, and 1 otherwise.
- CAPTURE: write exactly DEPTH samples into the FIFO, with no reads. After the DEPTH-th write, stop `ADC_CLK` (held 0) and go to DUMP.
- DUMP:
  - Emit header 0xA5.
  - Then emit 2 bytes per sample, oldest sample first, MSB byte first.
    - MSB byte: {`ADC_OTR`, zero padding, `ADC_BIT[ADC_W-1:8]`}.
    - LSB byte: `ADC_BIT[7:0]`.
  - Return to IDLE after the last byte is accepted.
- STREAM:
  - No header is sent.
  - Writes and reads run concurrently, using the same byte format.
  - A strobe with the FIFO full drops that sample and sets `OVERFLOW`.
  - A simultaneous read and write with the FIFO full is not a drop, because the read frees a slot first.
- FIFO wrap-around is by natural pointer overflow. Full and empty are distinguished by an extra pointer MSB.

## Timing
- Reset values: `ADC_CLK`=0, `ADC_OE`=1, `TX_VALID`=0, `TX_DATA`=0, `BUSY`=0, `OVERFLOW`=0. State=IDLE, divider=DIV_INIT, FIFO empty.
- A command byte takes effect on the cycle after `CMD_VALID`. `BUSY` rises the same cycle.
- The first `ADC_CLK` rise occurs DIV+1 cycles after entering CAPTURE or STREAM.
- Byte handshake:
  - `TX_DATA` and `TX_VALID` are registered.
  - A byte transfers on a cycle with `TX_VALID` && `TX_READY`.
  - Once raised, `TX_VALID` and `TX_DATA` hold stable until accepted. The only exception is command 0x00, which drops them the next cycle.
- The first byte is valid no earlier than 2 cycles after a sample is in a non-empty FIFO; this is the FIFO read latency.
- A 0x00 received mid-DUMP or mid-STREAM aborts within 1 cycle and discards any remaining data.
- `RST` overrides everything, including a coincident `CMD_VALID`.

## Structure
- Package `adc_stream_pkg` holds:
  - the state enumeration;
  - command constants CMD_STOP=0x00, CMD_CAPTURE=0x01, CMD_SETDIV=0x02, CMD_STREAM=0x03;
  - HEADER=0xA5.
- Sub-module `sync_fifo`:
  - parametrised width (ADC_W+1) and DEPTH;
  - registered read data;
  - full/empty flags and a flush input.
- The top level contains the divider, the FSM, and the byte serialiser.

## Test plan
- Reset, then no command: `ADC_CLK` stays 0, `ADC_OE` stays 1, `TX_VALID` stays 0 for 1000 cycles.
- SETDIV 0x02,0x03, then 0x01 with `ADC_BIT`=2019 (0x7E3) and OTR=0, `TX_READY`=1:
  - `ADC_CLK` period is 8 cycles;
  - output is 0xA5 followed by DEPTH×(0x07,0xE3);
  - then IDLE and `BUSY`=0.
- Capture with `ADC_OTR`=1 and `ADC_BIT`=0xFFF: MSB bytes are 0x8F.
- STREAM with `TX_READY` held 0: after DEPTH samples `OVERFLOW`=1. Then 0x00 clears `OVERFLOW`, the FIFO empties, and `ADC_OE`=1.
- 0x00 mid-DUMP with `TX_READY` toggling every cycle: `TX_VALID` is low the next cycle and no further bytes are emitted.
- Assert `RST` for 1 cycle mid-STREAM: all outputs return to their reset values and the divider returns to DIV_INIT.
